// File: rtl/issue_dispatch_pkg.sv
// issue_dispatch_pkg
//  Shared types and helpers for the dual-issue select stage.
//  - pc_set_t      : one decoded instruction as offered by the issue buffer
//  - issue_class_e : how many lanes issued in a cycle (perf accounting)
//  - is_load / is_mem / is_branch / is_csr : instruction classification
package issue_dispatch_pkg;

  localparam int REG_AW = 5;  // GPR index width (32 architectural registers)

  typedef struct packed {
    logic [31:0]       pc;
    logic [REG_AW-1:0] rf_raddr1;
    logic [REG_AW-1:0] rf_raddr2;
    logic [REG_AW-1:0] rf_rd;
    logic              rf_we;
    logic              mem_re;    // load
    logic              mem_we;    // store
    logic              br;        // branch / jump
    logic              csr;       // CSR access
    logic              ecode_we;  // raises an exception code
    logic              valid;     // set on the registered copy when the lane issued
  } pc_set_t;

  typedef enum logic [1:0] {
    ISSUE_NONE   = 2'd0,
    ISSUE_SINGLE = 2'd1,
    ISSUE_DUAL   = 2'd2
  } issue_class_e;

  function automatic logic is_load(input pc_set_t s);
    return s.mem_re;
  endfunction

  function automatic logic is_mem(input pc_set_t s);
    return s.mem_re | s.mem_we;
  endfunction

  function automatic logic is_branch(input pc_set_t s);
    return s.br;
  endfunction

  function automatic logic is_csr(input pc_set_t s);
    return s.csr;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//  Per-register countdown of cycles until a load result may be consumed.
//  Ports:
//    clk, rst   : clock, synchronous active-high reset (clears all counters)
//    hold       : freeze all counters (back-end stall)
//    clear      : zero all counters (flush; wins over hold)
//    raddr[4]   : source registers to test -> ready[4]
//    wr_en/wr_rd/wr_load [2] : issued writers (index 0 = lane A)
module issue_scoreboard
  import issue_dispatch_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   clear,
  input  logic [3:0][REG_AW-1:0] raddr,
  output logic [3:0]             ready,
  input  logic [1:0]             wr_en,
  input  logic [1:0][REG_AW-1:0] wr_rd,
  input  logic [1:0]             wr_load
);

  localparam int CNT_W = $clog2(LOAD_LAT) + 1;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ready[i] = (raddr[i] == '0) || (cnt_q[raddr[i]] == '0);
    end
  end

  always_comb begin
    // NOTE: every combinational output is given a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_d[i] = '0;
    end else if (!hold) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      // Writers are applied after the decrement so a new load wins.
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && (wr_rd[p] != '0)) begin
          cnt_d[wr_rd[p]] = wr_load[p] ? CNT_W'(LOAD_LAT - 1) : '0;
        end
      end
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is cheap and required.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/issue_dispatch.sv
// issue_dispatch
//  Dual-issue select stage after the issue buffer. Decides how many of the
//  two head entries issue (0/1/2), reports that count combinationally as the
//  buffer's consume count, and registers the pair into the lane-A/B EX regs.
//  Ports:
//    clk, rst               : clock, synchronous active-high reset
//    i_PC_set1/2, i_is_valid: buffer head entries and their valid bits
//    flush_BR               : mispredict flush (priority over stalls)
//    stall_DCache/stall_div : back-end freeze
//    o_usingNUM             : consume count returned to the buffer
//    o_PC_set_a/b, o_valid  : registered lane outputs
//    o_perf_*               : issue-class counters
//  Build option: define ISSUE_PERF_EN to compile the saturating perf
//  counters; otherwise the perf ports are tied to zero.
module issue_dispatch
  import issue_dispatch_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 2,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_set_t           i_PC_set1,
  input  pc_set_t           i_PC_set2,
  input  logic [1:0]        i_is_valid,
  input  logic              flush_BR,
  input  logic              stall_DCache,
  input  logic              stall_div,
  output logic [1:0]        o_usingNUM,
  output pc_set_t           o_PC_set_a,
  output pc_set_t           o_PC_set_b,
  output logic [1:0]        o_valid,
  output logic [PERF_W-1:0] o_perf_dual,
  output logic [PERF_W-1:0] o_perf_single,
  output logic [PERF_W-1:0] o_perf_bubble
);

  logic       stall;
  logic       issue_a;
  logic       issue_b;
  logic       pair_ok;
  logic [3:0] src_ready;

  pc_set_t    set_a_q, set_a_d;
  pc_set_t    set_b_q, set_b_d;
  logic [1:0] valid_q, valid_d;

  assign stall = stall_DCache | stall_div;

  issue_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LOAD_LAT (LOAD_LAT)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall & ~flush_BR),
    .clear   (flush_BR),
    .raddr   ({i_PC_set2.rf_raddr2, i_PC_set2.rf_raddr1,
               i_PC_set1.rf_raddr2, i_PC_set1.rf_raddr1}),
    .ready   (src_ready),
    .wr_en   ({issue_b & i_PC_set2.rf_we, issue_a & i_PC_set1.rf_we}),
    .wr_rd   ({i_PC_set2.rf_rd, i_PC_set1.rf_rd}),
    .wr_load ({is_load(i_PC_set2), is_load(i_PC_set1)})
  );

  always_comb begin
    issue_a = ~rst & ~flush_BR & ~stall & i_is_valid[1]
            & src_ready[0] & src_ready[1];

    // set2 may only join set1 when the pair is independent and fits the lanes.
    pair_ok = 1'b1;
    if (i_PC_set1.rf_we && (i_PC_set1.rf_rd != '0) &&
        ((i_PC_set2.rf_raddr1 == i_PC_set1.rf_rd) ||
         (i_PC_set2.rf_raddr2 == i_PC_set1.rf_rd)))                  pair_ok = 1'b0;
    if (i_PC_set1.rf_we && i_PC_set2.rf_we && (i_PC_set1.rf_rd != '0) &&
        (i_PC_set1.rf_rd == i_PC_set2.rf_rd))                         pair_ok = 1'b0;
    if (is_mem(i_PC_set1) && is_mem(i_PC_set2))                        pair_ok = 1'b0;
    if (is_branch(i_PC_set2) || is_csr(i_PC_set2) || i_PC_set2.ecode_we) pair_ok = 1'b0;

    issue_b = issue_a & i_is_valid[0] & src_ready[2] & src_ready[3] & pair_ok;

    o_usingNUM = {1'b0, issue_a} + {1'b0, issue_b};
  end

  always_comb begin
    set_a_d = set_a_q;
    set_b_d = set_b_q;
    valid_d = valid_q;
    if (flush_BR) begin
      valid_d = 2'b00;
    end else if (!stall) begin
      valid_d       = {issue_a, issue_b};
      set_a_d       = i_PC_set1;
      set_a_d.valid = issue_a;
      set_b_d       = i_PC_set2;
      set_b_d.valid = issue_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_a_q <= '0;
      set_b_q <= '0;
      valid_q <= 2'b00;
    end else begin
      set_a_q <= set_a_d;
      set_b_q <= set_b_d;
      valid_q <= valid_d;
    end
  end

  assign o_PC_set_a = set_a_q;
  assign o_PC_set_b = set_b_q;
  assign o_valid    = valid_q;

`ifdef ISSUE_PERF_EN
  issue_class_e      issue_class;
  logic [PERF_W-1:0] perf_dual_q, perf_dual_d;
  logic [PERF_W-1:0] perf_single_q, perf_single_d;
  logic [PERF_W-1:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    issue_class   = issue_b ? ISSUE_DUAL : (issue_a ? ISSUE_SINGLE : ISSUE_NONE);
    perf_dual_d   = perf_dual_q;
    perf_single_d = perf_single_q;
    perf_bubble_d = perf_bubble_q;
    if (!stall && !flush_BR) begin
      unique case (issue_class)
        ISSUE_DUAL:   if (~&perf_dual_q)   perf_dual_d   = perf_dual_q + PERF_W'(1);
        ISSUE_SINGLE: if (~&perf_single_q) perf_single_d = perf_single_q + PERF_W'(1);
        default: begin
          if ((i_is_valid != 2'b00) && ~&perf_bubble_q) perf_bubble_d = perf_bubble_q + PERF_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dual_q   <= '0;
      perf_single_q <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_dual_q   <= perf_dual_d;
      perf_single_q <= perf_single_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign o_perf_dual   = perf_dual_q;
  assign o_perf_single = perf_single_q;
  assign o_perf_bubble = perf_bubble_q;
`else
  assign o_perf_dual   = '0;
  assign o_perf_single = '0;
  assign o_perf_bubble = '0;
`endif

endmodule
